alu_arbiter_seq: RTL and testbench

//  Shares one N-bit ALU datapath between two requesters (port 0, port 1) with round-robin arbitration.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_divider_seq.sv | 75 +++++++
 rtl/alu_arbiter_seq.sv | 219 +++++++++++++++++++++
 tb/tb_alu_arbiter_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the arbitrated ALU sequencer: opcodes, sequencer states, port count.
package alu_pkg;

  localparam int RR_PORTS = 2;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_DIV = 4'd8,
    OP_MOD = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_RESP = 2'd3
  } seq_state_e;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_divider_seq.sv
// Restoring unsigned divider: loads on start, performs one quotient bit per cycle,
// pulses done once the N-th bit is in. b == 0 yields quot = all ones, rem = a.
module alu_divider_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] quot,
  output logic [N-1:0] rem,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  den_q, den_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [N:0]    part_s;
  logic [N-1:0]  diff_s;

  always_comb begin
    part_s = {rem_q, quot_q[N-1]};
    diff_s = part_s[N-1:0] - den_q;
    rem_d  = rem_q;
    quot_d = quot_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (start) begin
      rem_d  = {N{1'b0}};
      quot_d = a;
      den_d  = b;
      cnt_d  = CW'(N);
    end else if (cnt_q != {CW{1'b0}}) begin
      // the partial remainder stays below the divisor, so the difference fits in N bits
      if (part_s >= {1'b0, den_q}) begin
        rem_d  = diff_s;
        quot_d = {quot_q[N-2:0], 1'b1};
      end else begin
        rem_d  = part_s[N-1:0];
        quot_d = {quot_q[N-2:0], 1'b0};
      end
      cnt_d  = cnt_q - CW'(1);
      done_d = (cnt_q == CW'(1));
    end else begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= {N{1'b0}};
      quot_q <= {N{1'b0}};
      den_q  <= {N{1'b0}};
      cnt_q  <= {CW{1'b0}};
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;
  assign done = done_q;

endmodule

// File: rtl/alu_arbiter_seq.sv
// Two-port round-robin front end sharing one N-bit ALU with a sequential divider.
// Optional feature macro ALU_DIV0_TRAP_EN: DIV/MOD by zero returns all ones with err set.
module alu_arbiter_seq
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [RR_PORTS-1:0]        req_valid,
  output logic [RR_PORTS-1:0]        req_ready,
  input  logic [RR_PORTS-1:0][3:0]   req_op,
  input  logic [RR_PORTS-1:0][N-1:0] req_in1,
  input  logic [RR_PORTS-1:0][N-1:0] req_in2,
  output logic                       rsp_valid,
  output logic                       rsp_id,
  output logic [2*N-1:0]             rsp_result,
  output logic                       rsp_neg,
  output logic                       rsp_cero,
  output logic                       rsp_carry,
  output logic                       rsp_err,
  output logic                       busy
);

  localparam int SW = $clog2(N);
`ifdef ALU_DIV0_TRAP_EN
  localparam bit DIV0_TRAP = 1'b1;
`else
  localparam bit DIV0_TRAP = 1'b0;
`endif

  seq_state_e     state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic [3:0]     op_q, op_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic           id_q, id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_id_q, rsp_id_d;
  logic [2*N-1:0] rsp_result_q, rsp_result_d;
  logic           rsp_neg_q, rsp_neg_d;
  logic           rsp_cero_q, rsp_cero_d;
  logic           rsp_carry_q, rsp_carry_d;
  logic           rsp_err_q, rsp_err_d;

  logic           grant_s, hs_s, div_start_s, div_done_s;
  logic [N-1:0]   div_quot_s, div_rem_s;
  logic [2*N-1:0] res_s, mul_s;
  logic           neg_s, carry_s, err_s;
  logic [N:0]     add_s;
  logic [N-1:0]   sub_s, shl_s, shr_s;
  logic [SW-1:0]  shamt_s;

  always_comb begin
    grant_s   = req_valid[1];
    req_ready = {RR_PORTS{1'b0}};
    if (req_valid == 2'b11) begin
      grant_s = ~last_grant_q;
    end else begin
      grant_s = req_valid[1];
    end
    if ((state_q == ST_IDLE) && (req_valid != 2'b00)) begin
      req_ready = grant_s ? 2'b10 : 2'b01;
    end else begin
      req_ready = {RR_PORTS{1'b0}};
    end
  end

  assign hs_s        = |(req_valid & req_ready);
  assign div_start_s = hs_s && is_div_op(req_op[grant_s]) &&
                       !(DIV0_TRAP && (req_in2[grant_s] == {N{1'b0}}));

  alu_divider_seq #(.N(N)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start_s),
    .a     (req_in1[grant_s]),
    .b     (req_in2[grant_s]),
    .quot  (div_quot_s),
    .rem   (div_rem_s),
    .done  (div_done_s)
  );

  always_comb begin
    add_s   = {1'b0, a_q} + {1'b0, b_q};
    sub_s   = a_q - b_q;
    mul_s   = {{N{1'b0}}, a_q} * {{N{1'b0}}, b_q};
    shamt_s = b_q[SW-1:0];
    shl_s   = a_q << shamt_s;
    shr_s   = a_q >> shamt_s;
    res_s   = {(2*N){1'b0}};
    neg_s   = 1'b0;
    carry_s = 1'b0;
    err_s   = 1'b0;
    if (state_q == ST_DIV) begin
      res_s = {{N{1'b0}}, (op_q == OP_MOD) ? div_rem_s : div_quot_s};
    end else begin
      case (alu_op_e'(op_q))
        OP_ADD: begin
          res_s   = {{(N-1){1'b0}}, add_s};
          carry_s = add_s[N];
        end
        OP_SUB: begin
          res_s   = {{N{1'b0}}, sub_s};
          neg_s   = (a_q < b_q);
          carry_s = (a_q < b_q);
        end
        OP_MUL: res_s = mul_s;
        OP_AND: res_s = {{N{1'b0}}, a_q & b_q};
        OP_OR:  res_s = {{N{1'b0}}, a_q | b_q};
        OP_XOR: res_s = {{N{1'b0}}, a_q ^ b_q};
        OP_SHL: res_s = {{N{1'b0}}, shl_s};
        OP_SHR: res_s = {{N{1'b0}}, shr_s};
        // DIV/MOD only land in EXEC when the divide-by-zero trap fired
        OP_DIV, OP_MOD: begin
          res_s = {(2*N){1'b1}};
          err_s = 1'b1;
        end
        default: begin
          res_s = {{(2*N-1){1'b0}}, 1'b1};
          err_s = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_neg_d    = rsp_neg_q;
    rsp_cero_d   = rsp_cero_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_s) begin
          op_d         = req_op[grant_s];
          a_d          = req_in1[grant_s];
          b_d          = req_in2[grant_s];
          id_d         = grant_s;
          last_grant_d = grant_s;
          state_d      = div_start_s ? ST_DIV : ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_DIV: begin
        if (div_done_s) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // response fields are captured on entry to RESP and then held
    if (state_d == ST_RESP) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = id_q;
      rsp_result_d = res_s;
      rsp_neg_d    = neg_s;
      rsp_cero_d   = (res_s == {(2*N){1'b0}});
      rsp_carry_d  = carry_s;
      rsp_err_d    = err_s;
    end else begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      op_q         <= 4'd0;
      a_q          <= {N{1'b0}};
      b_q          <= {N{1'b0}};
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= {(2*N){1'b0}};
      rsp_neg_q    <= 1'b0;
      rsp_cero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_neg_q    <= rsp_neg_d;
      rsp_cero_q   <= rsp_cero_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_neg    = rsp_neg_q;
  assign rsp_cero   = rsp_cero_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Table-driven bench for alu_arbiter_seq (N=4) with a response scoreboard.
module tb_alu_arbiter_seq;

  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          req_valid, req_ready;
  logic [1:0][3:0]     req_op;
  logic [1:0][N-1:0]   req_in1, req_in2;
  logic                rsp_valid, rsp_id, rsp_neg, rsp_cero, rsp_carry, rsp_err, busy;
  logic [2*N-1:0]      rsp_result;

  always #5 clk = ~clk;

  alu_arbiter_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_in1(req_in1), .req_in2(req_in2),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_neg(rsp_neg), .rsp_cero(rsp_cero), .rsp_carry(rsp_carry),
    .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct {
    logic           port;
    logic [3:0]     op;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] res;
    logic           neg;
    logic           carry;
    logic           err;
    int             lat;
  } vec_t;

  typedef struct {
    logic           id;
    logic [2*N-1:0] res;
    logic [3:0]     flags;
    int             lat;
    int             t;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[23];
  vec_t va, vb;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input vec_t v, input int t);
    exp_t e;
    e.id    = v.port;
    e.res   = v.res;
    e.flags = {v.neg, (v.res == {(2*N){1'b0}}), v.carry, v.err};
    e.lat   = v.lat;
    e.t     = t;
    sb.push_back(e);
  endtask

  // scoreboard consumer: every rsp_valid pulse must match the oldest issued command
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=rsp_valid result=%0h required=no response", rsp_result);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
        check("rsp_result", 64'(rsp_result), 64'(mon_e.res));
        check("rsp_flags_neg_cero_carry_err", 64'({rsp_neg, rsp_cero, rsp_carry, rsp_err}), 64'(mon_e.flags));
        check("rsp_latency", 64'(cyc - mon_e.t), 64'(mon_e.lat));
        check("busy_ready_in_resp", 64'({busy, req_ready}), 64'(3'b100));
      end
    end
  end

  task automatic send(input vec_t v0, input vec_t v1, input logic [1:0] en);
    logic [1:0] pend;
    logic [1:0] hit;
    int g;
    pend = en;
    g = 0;
    @(posedge clk); #1;
    if (en[0]) begin
      req_valid[0] = 1'b1; req_op[0] = v0.op; req_in1[0] = v0.a; req_in2[0] = v0.b;
    end
    if (en[1]) begin
      req_valid[1] = 1'b1; req_op[1] = v1.op; req_in1[1] = v1.a; req_in2[1] = v1.b;
    end
    while ((pend != 2'b00) && (g < 60)) begin
      @(negedge clk);
      hit = pend & req_ready;
      if (hit[0]) push(v0, cyc);
      if (hit[1]) push(v1, cyc);
      pend = pend & ~hit;
      @(posedge clk); #1;
      req_valid = req_valid & ~hit;
      g++;
    end
    check("handshake_done", 64'(pend), 64'(2'b00));
    req_valid = 2'b00;
  endtask

  task automatic send1(input vec_t v);
    send(v, v, v.port ? 2'b10 : 2'b01);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0) && (g < 40)) begin
      @(negedge clk);
      g++;
    end
    check("drain_pending", 64'(sb.size()), 64'(0));
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; req_op = '0; req_in1 = '0; req_in2 = '0;

    //           port  op     a      b      res     neg   carry err   lat
    tbl[0]  = '{1'b0, 4'd0, 4'h9, 4'h8, 8'h11, 1'b0, 1'b1, 1'b0, 2};
    tbl[1]  = '{1'b1, 4'd0, 4'hF, 4'hF, 8'h1E, 1'b0, 1'b1, 1'b0, 2};
    tbl[2]  = '{1'b0, 4'd0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 2};
    tbl[3]  = '{1'b0, 4'd1, 4'h3, 4'h5, 8'h0E, 1'b1, 1'b1, 1'b0, 2};
    tbl[4]  = '{1'b1, 4'd1, 4'h9, 4'h4, 8'h05, 1'b0, 1'b0, 1'b0, 2};
    tbl[5]  = '{1'b0, 4'd2, 4'hF, 4'hF, 8'hE1, 1'b0, 1'b0, 1'b0, 2};
    tbl[6]  = '{1'b1, 4'd2, 4'h3, 4'h5, 8'h0F, 1'b0, 1'b0, 1'b0, 2};
    tbl[7]  = '{1'b0, 4'd3, 4'hC, 4'hA, 8'h08, 1'b0, 1'b0, 1'b0, 2};
    tbl[8]  = '{1'b1, 4'd4, 4'hC, 4'hA, 8'h0E, 1'b0, 1'b0, 1'b0, 2};
    tbl[9]  = '{1'b0, 4'd5, 4'hC, 4'hA, 8'h06, 1'b0, 1'b0, 1'b0, 2};
    tbl[10] = '{1'b1, 4'd6, 4'hB, 4'h2, 8'h0C, 1'b0, 1'b0, 1'b0, 2};
    tbl[11] = '{1'b0, 4'd6, 4'h1, 4'h7, 8'h08, 1'b0, 1'b0, 1'b0, 2};
    tbl[12] = '{1'b1, 4'd7, 4'hB, 4'h1, 8'h05, 1'b0, 1'b0, 1'b0, 2};
    tbl[13] = '{1'b0, 4'd7, 4'hF, 4'h6, 8'h03, 1'b0, 1'b0, 1'b0, 2};
    tbl[14] = '{1'b1, 4'd8, 4'hD, 4'h4, 8'h03, 1'b0, 1'b0, 1'b0, 6};
    tbl[15] = '{1'b1, 4'd9, 4'hD, 4'h4, 8'h01, 1'b0, 1'b0, 1'b0, 6};
    tbl[16] = '{1'b0, 4'd8, 4'hF, 4'h3, 8'h05, 1'b0, 1'b0, 1'b0, 6};
    tbl[17] = '{1'b0, 4'd9, 4'hE, 4'h5, 8'h04, 1'b0, 1'b0, 1'b0, 6};
    tbl[18] = '{1'b0, 4'd8, 4'h2, 4'h7, 8'h00, 1'b0, 1'b0, 1'b0, 6};
    tbl[19] = '{1'b1, 4'hC, 4'h5, 4'h5, 8'h01, 1'b0, 1'b0, 1'b1, 2};
    tbl[20] = '{1'b0, 4'hF, 4'h0, 4'h0, 8'h01, 1'b0, 1'b0, 1'b1, 2};
`ifdef ALU_DIV0_TRAP_EN
    tbl[21] = '{1'b0, 4'd8, 4'h7, 4'h0, 8'hFF, 1'b0, 1'b0, 1'b1, 2};
    tbl[22] = '{1'b1, 4'd9, 4'h7, 4'h0, 8'hFF, 1'b0, 1'b0, 1'b1, 2};
`else
    tbl[21] = '{1'b0, 4'd8, 4'h7, 4'h0, 8'h0F, 1'b0, 1'b0, 1'b0, 6};
    tbl[22] = '{1'b1, 4'd9, 4'h7, 4'h0, 8'h07, 1'b0, 1'b0, 1'b0, 6};
`endif

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_rsp_bits", 64'({rsp_valid, rsp_id, rsp_neg, rsp_cero, rsp_carry, rsp_err, busy}), 64'(7'b0));
    check("reset_rsp_result", 64'(rsp_result), 64'(8'h00));
    check("reset_ready_idle", 64'(req_ready), 64'(2'b00));

    // both ports valid right after reset: port0 first, then port1
    va = '{1'b0, 4'd1, 4'h3, 4'h5, 8'h0E, 1'b1, 1'b1, 1'b0, 2};
    vb = '{1'b1, 4'd3, 4'hF, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 2};
    send(va, vb, 2'b11);
    drain();

    // single ADD, then result must hold after the response pulse
    va = '{1'b0, 4'd0, 4'h9, 4'h8, 8'h11, 1'b0, 1'b1, 1'b0, 2};
    send1(va);
    drain();
    @(negedge clk);
    check("hold_after_resp", 64'({rsp_valid, busy, rsp_carry, rsp_id, rsp_result}), 64'({1'b0, 1'b0, 1'b1, 1'b0, 8'h11}));

    for (int i = 0; i < 23; i++) begin
      send1(tbl[i]);
      drain();
    end

    // reset during the second DIV cycle drops the command
    @(posedge clk); #1;
    req_valid = 2'b01; req_op[0] = 4'd8; req_in1[0] = 4'hD; req_in2[0] = 4'h4;
    @(negedge clk);
    check("mid_rst_grant", 64'(req_ready), 64'(2'b01));
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_idle", 64'({busy, rsp_valid, rsp_result}), 64'(10'h000));
    repeat (10) @(negedge clk);
    check("mid_rst_still_idle", 64'(busy), 64'(1'b0));

    va = '{1'b0, 4'd0, 4'h1, 4'h2, 8'h03, 1'b0, 1'b0, 1'b0, 2};
    vb = '{1'b1, 4'd5, 4'h5, 4'h5, 8'h00, 1'b0, 1'b0, 1'b0, 2};
    send(va, vb, 2'b11);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
